// File: rtl/isa_test_monitor.sv
// isa_test_monitor: snoops register-file writebacks and turns the riscv-tests done/result protocol into registered status.
// Optional watchdog/TIMEOUT state enabled by defining ISA_MON_TIMEOUT_EN.
module isa_test_monitor #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned DONE_REG       = 26,
    parameter int unsigned RESULT_REG     = 27,
    parameter int unsigned TESTNUM_REG    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] fail_code,
    output logic [31:0] cycle_count
);
    localparam logic [1:0] RUN = 2'd0, SETTLE = 2'd1, DONE_ST = 2'd2, TIMEOUT_ST = 2'd3;
`ifdef ISA_MON_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic [1:0]  state;
    logic [7:0]  settle_cnt;
    logic [31:0] sh_num, sh_res;
    logic        wr_ok, done_wr, num_wr, res_wr, limit, running;
    assign wr_ok   = wb_en && wb_addr != 5'd0;
    assign done_wr = wr_ok && wb_addr == 5'(DONE_REG) && wb_data != 32'd0;
    assign num_wr  = wr_ok && wb_addr == 5'(TESTNUM_REG);
    assign res_wr  = wr_ok && wb_addr == 5'(RESULT_REG);
    // constant-folds away when the watchdog is compiled out
    assign limit   = TO_EN && cycle_count == 32'(TIMEOUT_CYCLES);
    assign running = state == RUN || state == SETTLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            settle_cnt  <= 8'd0;
            sh_num      <= 32'd0;
            sh_res      <= 32'd0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= 32'd0;
            cycle_count <= 32'd0;
        end else begin
            if (num_wr) sh_num <= wb_data;
            if (res_wr) sh_res <= wb_data;
            if (running) cycle_count <= cycle_count + 32'(cycle_count != '1);
            if (state == RUN && done_wr) begin
                state      <= SETTLE;
                settle_cnt <= 8'(SETTLE_CYCLES);
            end else if (state == RUN && limit) begin
                state     <= TIMEOUT_ST;
                done      <= 1'b1;
                timeout   <= 1'b1;
                fail_code <= sh_num;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 8'd1;
                // verdict uses shadows as of the previous edge, so a result write on the final edge is excluded
                if (settle_cnt == 8'd1) begin
                    state     <= DONE_ST;
                    done      <= 1'b1;
                    pass      <= sh_res == 32'd1;
                    fail_code <= sh_res == 32'd1 ? 32'd0 : sh_num;
                end
            end
        end
    end
endmodule

// File: tb/tb_isa_test_monitor.sv
// tb_isa_test_monitor: directed self-checking bench for isa_test_monitor (SETTLE_CYCLES=2, TIMEOUT_CYCLES=50).
module tb_isa_test_monitor;
    logic        clk = 1'b0, rst = 1'b1, wb_en = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        done, pass, timeout;
    logic [31:0] fail_code, cycle_count;
    int checks = 0, failures = 0;
`ifdef ISA_MON_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    isa_test_monitor #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; wb_en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({done, pass, timeout} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {done, pass, timeout}); end
        checks++; if (fail_code !== 32'd0) begin failures++; $display("FAIL reset_fail_code got=%0d exp=0", fail_code); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_cycle_count got=%0d exp=0", cycle_count); end
    endtask

    task automatic test_pass();
        do_reset();
        wr(5'd27, 32'd1);
        idle(8);
        wr(5'd26, 32'd1);
        idle(1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL pass_early_done got=%b exp=0", done); end
        idle(1);
        checks++; if ({done, pass, timeout} !== 3'b110) begin failures++; $display("FAIL pass_flags got=%b exp=110", {done, pass, timeout}); end
        checks++; if (fail_code !== 32'd0) begin failures++; $display("FAIL pass_fail_code got=%0d exp=0", fail_code); end
        checks++; if (cycle_count !== 32'd12) begin failures++; $display("FAIL pass_cycle_count got=%0d exp=12", cycle_count); end
        idle(3);
        checks++; if (cycle_count !== 32'd12) begin failures++; $display("FAIL pass_count_frozen got=%0d exp=12", cycle_count); end
    endtask

    task automatic test_fail();
        do_reset();
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        idle(2);
        checks++; if ({done, pass} !== 2'b10) begin failures++; $display("FAIL fail_flags got=%b exp=10", {done, pass}); end
        checks++; if (fail_code !== 32'd5) begin failures++; $display("FAIL fail_code got=%0d exp=5", fail_code); end
        wr(5'd27, 32'd1);
        wr(5'd3, 32'd9);
        idle(1);
        checks++; if ({done, pass} !== 2'b10) begin failures++; $display("FAIL fail_absorb_flags got=%b exp=10", {done, pass}); end
        checks++; if (fail_code !== 32'd5) begin failures++; $display("FAIL fail_absorb_code got=%0d exp=5", fail_code); end
    endtask

    task automatic test_late_result();
        do_reset();
        wr(5'd26, 32'd1);
        wr(5'd27, 32'd1);
        idle(1);
        checks++; if ({done, pass} !== 2'b11) begin failures++; $display("FAIL late_in_window got=%b exp=11", {done, pass}); end
        do_reset();
        wr(5'd3, 32'd4);
        wr(5'd26, 32'd1);
        idle(1);
        wr(5'd27, 32'd1);
        checks++; if ({done, pass} !== 2'b10) begin failures++; $display("FAIL late_too_late got=%b exp=10", {done, pass}); end
        checks++; if (fail_code !== 32'd4) begin failures++; $display("FAIL late_fail_code got=%0d exp=4", fail_code); end
    endtask

    task automatic test_ignored();
        do_reset();
        wr(5'd26, 32'd0);
        idle(3);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ign_zero_done got=%b exp=0", done); end
        wr(5'd0, 32'd1);
        wr(5'd26, 32'd1);
        wr(5'd26, 32'd1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ign_restart_early got=%b exp=0", done); end
        idle(1);
        checks++; if ({done, pass} !== 2'b10) begin failures++; $display("FAIL ign_settle_latency got=%b exp=10", {done, pass}); end
        checks++; if (fail_code !== 32'd0) begin failures++; $display("FAIL ign_fail_code got=%0d exp=0", fail_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        wr(5'd3, 32'd7);
        idle(49);
        checks++; if ({done, timeout} !== 2'b00) begin failures++; $display("FAIL to_before got=%b exp=00", {done, timeout}); end
        checks++; if (cycle_count !== 32'd50) begin failures++; $display("FAIL to_count got=%0d exp=50", cycle_count); end
        idle(1);
        checks++; if ({done, timeout, pass} !== {TO_EN, TO_EN, 1'b0}) begin failures++; $display("FAIL to_flags got=%b exp=%b", {done, timeout, pass}, {TO_EN, TO_EN, 1'b0}); end
        checks++; if (fail_code !== (TO_EN ? 32'd7 : 32'd0)) begin failures++; $display("FAIL to_fail_code got=%0d exp=%0d", fail_code, TO_EN ? 7 : 0); end
        do_reset();
        idle(50);
        wr(5'd26, 32'd1);
        checks++; if ({done, timeout} !== 2'b00) begin failures++; $display("FAIL to_race_settle got=%b exp=00", {done, timeout}); end
        idle(2);
        checks++; if ({done, timeout, pass} !== 3'b100) begin failures++; $display("FAIL to_race_done got=%b exp=100", {done, timeout, pass}); end
    endtask

    task automatic test_reset_mid_settle();
        do_reset();
        wr(5'd3, 32'd2);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(1);
        #3 rst = 1'b1;
        #1;
        checks++; if ({done, pass, timeout} !== 3'b000) begin failures++; $display("FAIL mid_rst_flags got=%b exp=000", {done, pass, timeout}); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", cycle_count); end
        #2 rst = 1'b0;
        idle(3);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_no_verdict got=%b exp=0", done); end
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(2);
        checks++; if ({done, pass} !== 2'b11) begin failures++; $display("FAIL mid_rst_fresh got=%b exp=11", {done, pass}); end
        checks++; if (cycle_count !== 32'd7) begin failures++; $display("FAIL mid_rst_fresh_count got=%0d exp=7", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_late_result();
        test_ignored();
        test_timeout();
        test_reset_mid_settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
